// File: rtl/census_pkg.sv
// rtl/census_pkg.sv - shared census sizing helpers: code width, window radius, counter widths
package census_pkg;

    // One comparison bit per window pixel, the center is not compared with itself.
    function automatic int code_width(input int window_size);
        return window_size * window_size - 1;
    endfunction

    function automatic int radius(input int window_size);
        return (window_size - 1) / 2;
    endfunction

    // Width of a position counter covering 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/census_linebuf.sv
// rtl/census_linebuf.sv - per-column stack of the previous LINES image rows
module census_linebuf #(
    parameter int WIDTH       = 320,
    parameter int LINES       = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_W      = 9
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [PIXEL_WIDTH-1:0]         din,
    output logic [LINES*PIXEL_WIDTH-1:0]   dout
);

    // Line k holds the pixel of row (current-1-k) at each column; contents are never reset.
    logic [PIXEL_WIDTH-1:0] mem_q [LINES][WIDTH];

    // Read the whole column stack at the addressed column.
    always_comb begin
        dout = '0;
        for (int k = 0; k < LINES; k++) begin
            dout[k*PIXEL_WIDTH +: PIXEL_WIDTH] = mem_q[k][addr];
        end
    end

    // On accept, push the new pixel onto the column stack and drop the oldest row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[0][addr] <= din;
            for (int k = 1; k < LINES; k++) begin
                mem_q[k][addr] <= mem_q[k-1][addr];
            end
        end
    end

endmodule

// File: rtl/census_stream.sv
// rtl/census_stream.sv - streaming census transform; CENSUS_THRESH_EN adds a thresh input
module census_stream
    import census_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int WINDOW_SIZE = 5,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [PIXEL_WIDTH-1:0]                        s_pixel,
    input  logic                                          s_valid,
    input  logic                                          s_sof,
    output logic                                          s_ready,
`ifdef CENSUS_THRESH_EN
    input  logic [PIXEL_WIDTH-1:0]                        thresh,
`endif
    output logic [census_pkg::code_width(WINDOW_SIZE)-1:0] m_code,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic                                          m_sof,
    output logic                                          m_eol
);

    localparam int WS         = WINDOW_SIZE;
    localparam int PW         = PIXEL_WIDTH;
    localparam int R          = radius(WS);
    localparam int CODE_W     = code_width(WS);
    localparam int LINES      = WS - 1;
    localparam int COL_W      = cnt_width(WIDTH);
    localparam int ROW_W      = cnt_width(HEIGHT);
    localparam int CENTER_IDX = R * WS + R;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_START = COL_W'(2 * R);
    localparam logic [ROW_W-1:0] ROW_START = ROW_W'(2 * R);

    logic [COL_W-1:0]  col_q, col_d, pix_col;
    logic [ROW_W-1:0]  row_q, row_d, pix_row;
    logic              accept, qualify;

    logic [LINES*PW-1:0] lb_dout;
    logic [WS*PW-1:0]    cur_col;
    logic [WS*PW-1:0]    win_q [2*R];
    logic [WS*PW-1:0]    win_d [2*R];
    logic [PW-1:0]       win_px [WS][WS];
    logic [PW-1:0]       center_px, ref_px;
    logic [CODE_W-1:0]   census_bits;

    logic [CODE_W-1:0]   m_code_q, m_code_d;
    logic                m_valid_q, m_valid_d;
    logic                m_sof_q, m_sof_d;
    logic                m_eol_q, m_eol_d;

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;
    assign m_code  = m_code_q;
    assign m_valid = m_valid_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;

    // Position of the pixel on the input this cycle; s_sof overrides the running count.
    always_comb begin
        pix_col = s_sof ? '0 : col_q;
        pix_row = s_sof ? '0 : row_q;
        qualify = accept && (pix_row >= ROW_START) && (pix_col >= COL_START);
    end

    // Advance the raster position past the accepted pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pix_col == COL_LAST) begin
                col_d = '0;
                row_d = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
            end else begin
                col_d = pix_col + COL_W'(1);
                row_d = pix_row;
            end
        end
    end

    // Raster position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    census_linebuf #(
        .WIDTH       (WIDTH),
        .LINES       (LINES),
        .PIXEL_WIDTH (PW),
        .ADDR_W      (COL_W)
    ) u_linebuf (
        .clk   (clk),
        .wr_en (accept),
        .addr  (pix_col),
        .din   (s_pixel),
        .dout  (lb_dout)
    );

    // Current window column, index 0 is the oldest (top) row, the live pixel is the bottom.
    always_comb begin
        cur_col = '0;
        for (int i = 0; i < LINES; i++) begin
            cur_col[i*PW +: PW] = lb_dout[(LINES-1-i)*PW +: PW];
        end
        cur_col[LINES*PW +: PW] = s_pixel;
    end

    // Shift the 2R previous columns left on every accept.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int k = 0; k < 2*R-1; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[2*R-1] = cur_col;
        end
    end

    // Column history holds only pixel data, so it needs no reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    // Assemble the full window: stored columns on the left, live column on the right.
    always_comb begin
        for (int r = 0; r < WS; r++) begin
            for (int c = 0; c < 2*R; c++) begin
                win_px[r][c] = win_q[c][r*PW +: PW];
            end
            win_px[r][2*R] = cur_col[r*PW +: PW];
        end
    end

    assign center_px = win_px[R][R];

    // Comparison reference: the center, optionally raised by thresh and saturated.
`ifdef CENSUS_THRESH_EN
    logic [PW:0] ref_sum;
    always_comb begin
        ref_sum = {1'b0, center_px} + {1'b0, thresh};
        ref_px  = ref_sum[PW] ? {PW{1'b1}} : ref_sum[PW-1:0];
    end
`else
    always_comb begin
        ref_px = center_px;
    end
`endif

    // One bit per neighbor in window raster order, skipping the center.
    always_comb begin
        census_bits = '0;
        for (int r = 0; r < WS; r++) begin
            for (int c = 0; c < WS; c++) begin
                if (r*WS + c < CENTER_IDX) begin
                    census_bits[r*WS + c] = (win_px[r][c] >= ref_px);
                end else if (r*WS + c > CENTER_IDX) begin
                    census_bits[r*WS + c - 1] = (win_px[r][c] >= ref_px);
                end
            end
        end
    end

    // Output register: load on a qualifying accept, drop valid once consumed, hold while stalled.
    always_comb begin
        m_code_d  = m_code_q;
        m_valid_d = m_valid_q;
        m_sof_d   = m_sof_q;
        m_eol_d   = m_eol_q;
        if (qualify) begin
            m_code_d  = census_bits;
            m_valid_d = 1'b1;
            m_sof_d   = (pix_row == ROW_START) && (pix_col == COL_START);
            m_eol_d   = (pix_col == COL_LAST);
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_code_q  <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
        end else begin
            m_code_q  <= m_code_d;
            m_valid_q <= m_valid_d;
            m_sof_q   <= m_sof_d;
            m_eol_q   <= m_eol_d;
        end
    end

endmodule

// File: tb/tb_census_stream.sv
// tb/tb_census_stream.sv - randomized self-checking bench for census_stream (8x6, 3x3 window)
module tb_census_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WS = 3;
    localparam int R  = 1;
    localparam int CW = WS * WS - 1;
    localparam int NCODES = (H - 2*R) * (W - 2*R);
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_pixel = '0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          s_ready;
    logic [7:0]    thresh = '0;
    logic [CW-1:0] m_code;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_sof;
    logic          m_eol;

    census_stream #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .WINDOW_SIZE (WS),
        .PIXEL_WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_pixel (s_pixel),
        .s_valid (s_valid),
        .s_sof   (s_sof),
        .s_ready (s_ready),
`ifdef CENSUS_THRESH_EN
        .thresh  (thresh),
`endif
        .m_code  (m_code),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sof   (m_sof),
        .m_eol   (m_eol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] code;
        logic          sof;
        logic          eol;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   gaps = 0;
    int   rcnt = 0;
    int   cen_v = 0;
    int   nb_v = 0;
    int   mrow = 0;
    int   mcol = 0;
    logic [7:0] img [H][W];
    out_t exp_q[$];
    out_t log_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Census code of the window whose bottom-right pixel is (r,c), straight from the image.
    function automatic logic [CW-1:0] model_code(input int r, input int c, input int th);
        logic [CW-1:0] v;
        int k, cen, refv;
        v = '0;
        k = 0;
        cen = int'(img[r-R][c-R]);
        refv = cen + th;
        if (refv > 255) refv = 255;
        for (int dr = 0; dr < WS; dr++) begin
            for (int dc = 0; dc < WS; dc++) begin
                if (!(dr == R && dc == R)) begin
                    v[k] = (int'(img[r-2*R+dr][c-2*R+dc]) >= refv);
                    k++;
                end
            end
        end
        return v;
    endfunction

    // Compare process: every cycle away from the clock edge.
    logic          prev_stall = 1'b0;
    out_t          prev_out;
    always @(negedge clk) begin : monitor
        int r, c;
        out_t e, got;
        if (!rst_n) begin
            exp_q.delete();
            mrow = 0;
            mcol = 0;
            prev_stall = 1'b0;
        end else begin
            got = '{code: m_code, sof: m_sof, eol: m_eol};
            chk("s_ready_rule", int'(s_ready), (!m_valid || m_ready) ? 1 : 0);
            chk("m_valid_pending", int'(m_valid), (exp_q.size() != 0) ? 1 : 0);
            if (prev_stall) begin
                chk("stall_valid", int'(m_valid), 1);
                chk("stall_stable", int'(got), int'(prev_out));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("code", int'(m_code), int'(e.code));
                    chk("sof", int'(m_sof), int'(e.sof));
                    chk("eol", int'(m_eol), int'(e.eol));
                end
                log_q.push_back(got);
            end
            prev_stall = m_valid && !m_ready;
            prev_out = got;
            if (s_valid && s_ready) begin
                r = s_sof ? 0 : mrow;
                c = s_sof ? 0 : mcol;
                img[r][c] = s_pixel;
                if (r >= 2*R && c >= 2*R) begin
                    e.code = model_code(r, c, int'(thresh));
                    e.sof  = (r == 2*R && c == 2*R);
                    e.eol  = (c == W - 1);
                    exp_q.push_back(e);
                end
                if (c == W - 1) begin
                    mcol = 0;
                    mrow = (r == H - 1) ? 0 : r + 1;
                end else begin
                    mcol = c + 1;
                    mrow = r;
                end
            end
        end
    end

    // Downstream ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = (rcnt % 3 == 0); rcnt++; end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic sof);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (gaps != 0 && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_pixel = p;
        s_sof   = sof;
        while (!done) begin
            @(negedge clk);
            done = s_ready;
            tick();
            n++;
            if (!done && n >= TIMEOUT) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=%0d expected=<%0d", n, TIMEOUT);
                done = 1;
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0: return 8'h40;
            1: return 8'(c * 16);
            2: return ($urandom_range(0, 1) != 0) ? 8'(100 + $urandom_range(0, 3))
                                                  : 8'($urandom_range(0, 255));
            default: return (r == 1 && c == 1) ? 8'(cen_v) : 8'(nb_v);
        endcase
    endfunction

    task automatic send_frame(input int kind, input int npix);
        for (int i = 0; i < npix; i++) begin
            send_pixel(pix_of(kind, i / W, i % W), (i == 0));
        end
    endtask

    task automatic drain();
        ready_mode = 0;
        repeat (6) tick();
    endtask

    task automatic check_log(input string tag, input int exp_code);
        chk({tag, "_count"}, log_q.size(), NCODES);
        foreach (log_q[i]) begin
            chk({tag, "_code"}, int'(log_q[i].code), exp_code);
            chk({tag, "_sof"}, int'(log_q[i].sof), (i == 0) ? 1 : 0);
            chk({tag, "_eol"}, int'(log_q[i].eol), (i % (W - 2*R) == W - 2*R - 1) ? 1 : 0);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_code", int'(m_code), 0);
        chk("rst_m_sof", int'(m_sof), 0);
        chk("rst_m_eol", int'(m_eol), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        rst_n = 1'b1;
        tick();

        // Constant frame: every neighbor equals the center.
        log_q.delete();
        send_frame(0, W * H);
        drain();
        check_log("const", 8'hFF);

        // Horizontal ramp.
        log_q.delete();
        send_frame(1, W * H);
        drain();
        check_log("ramp", 8'b1101_0110);

        // Same ramp with 1-of-3 ready and gappy valid.
        gaps = 1;
        ready_mode = 1;
        log_q.delete();
        send_frame(1, W * H);
        drain();
        check_log("ramp_stall", 8'b1101_0110);

        // Random content under random backpressure.
        for (int f = 0; f < 3; f++) begin
            ready_mode = 2;
            send_frame(2, W * H);
        end
        drain();

        // Restart at pixel (3,4) of the current frame.
        gaps = 0;
        log_q.delete();
        send_frame(1, 3 * W + 4);
        send_frame(1, W * H);
        drain();
        chk("sof_restart_count", log_q.size(), (W - 2*R) + 2 + NCODES);
        if (log_q.size() > 8) begin
            chk("sof_restart_old_first", int'(log_q[0].sof), 1);
            chk("sof_restart_before", int'(log_q[7].sof), 0);
            chk("sof_restart_new_first", int'(log_q[8].sof), 1);
            chk("sof_restart_code", int'(log_q[8].code), 8'b1101_0110);
        end

        // Reset while the output is stalled.
        ready_mode = 3;
        tick();
        send_frame(0, 2 * W + 3);
        repeat (2) tick();
        chk("stall_before_reset", int'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_s_ready", int'(s_ready), 1);
        repeat (2) tick();
        rst_n = 1'b1;
        ready_mode = 0;
        tick();
        log_q.delete();
        send_frame(0, W * H);
        drain();
        check_log("after_reset", 8'hFF);

`ifdef CENSUS_THRESH_EN
        cen_v = 100; nb_v = 104; thresh = 8'd5;
        log_q.delete();
        send_frame(3, W * H);
        drain();
        if (log_q.size() > 0) chk("thresh5", int'(log_q[0].code), 0);
        thresh = 8'd4;
        log_q.delete();
        send_frame(3, W * H);
        drain();
        if (log_q.size() > 0) chk("thresh4", int'(log_q[0].code), 8'hFF);
        cen_v = 250; nb_v = 255; thresh = 8'd10;
        log_q.delete();
        send_frame(3, W * H);
        drain();
        if (log_q.size() > 0) chk("thresh_sat", int'(log_q[0].code), 8'hFF);
        thresh = 8'd0;
`endif

        chk("queue_empty_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
